blink_multi: RTL and testbench

Multi-channel LED blinker: next generation of the single-channel blink block. One shared free-running counter drives NCH independent LED channels. Each channel is runtime-configurable for mode (off, on, blink, counted burst) and blink rate. The block sits between the board-level LED pins and the control logic that writes its configuration port.

---
 rtl/blink_multi.sv | 145 ++++++++++++++
 tb/tb_blink_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_multi.sv
// Multi-channel LED blinker: one shared free-running counter paces NCH channels (OFF/ON/BLINK/BURST).
// Define BLINK_BURST_EN to compile in counted bursts; otherwise mode 3 behaves as BLINK and done is 0.
module blink_multi #(
    parameter int CBITS = 14,
    parameter int NCH   = 4,
    parameter int BW    = 8,
    localparam int DW   = $clog2(CBITS),
    localparam int CW   = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [1:0]      cfg_mode,
    input  logic [DW-1:0]   cfg_div,
    input  logic [BW-1:0]   cfg_cnt,
    output logic [NCH-1:0]  led,
    output logic            flg,
    output logic [NCH-1:0]  done
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    localparam logic [CBITS-1:0] ONES = '1;

    logic [CBITS-1:0] cnt;
    mode_t            mode_q [NCH];
    mode_t            mode_d [NCH];
    logic [DW-1:0]    div_q  [NCH];
    logic [DW-1:0]    div_d  [NCH];
    logic [NCH-1:0]   phase_q;
    logic [NCH-1:0]   phase_d;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   led_d;
    logic [DW-1:0]    div_in;
    logic [31:0]      div_wide;

`ifdef BLINK_BURST_EN
    logic [BW:0]      rem_q  [NCH];
    logic [BW:0]      rem_d  [NCH];
    logic [NCH-1:0]   done_d;
`endif

    // Out-of-range rate selects saturate at the slowest rate the counter supports.
    always_comb begin
        div_wide = 32'(cfg_div);
        div_in   = cfg_div;
        if (div_wide > 32'(CBITS - 1)) begin
            div_in = DW'(CBITS - 1);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mode_d[i]  = mode_q[i];
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
`ifdef BLINK_BURST_EN
            rem_d[i]   = rem_q[i];
            done_d[i]  = 1'b0;
`endif
            tick[i]  = (cnt & (ONES >> (CBITS - 1 - int'(div_q[i])))) == '0;
            led_d[i] = (mode_q[i] == MODE_ON) ||
                       (((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BURST)) && phase_q[i]);

            // A write takes priority over this channel's tick, and silently aborts a burst.
            if (cfg_we && (32'(cfg_ch) == 32'(i))) begin
                mode_d[i]  = mode_t'(cfg_mode);
                div_d[i]   = div_in;
                phase_d[i] = 1'b0;
`ifdef BLINK_BURST_EN
                rem_d[i]   = {cfg_cnt, 1'b0};
`endif
            end else begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (tick[i]) phase_d[i] = ~phase_q[i];
                    end
                    MODE_BURST: begin
`ifdef BLINK_BURST_EN
                        if (rem_q[i] == '0) begin
                            mode_d[i] = MODE_OFF;
                            done_d[i] = 1'b1;
                        end else if (tick[i]) begin
                            phase_d[i] = ~phase_q[i];
                            rem_d[i]   = rem_q[i] - 1'b1;
                            if (rem_q[i] == (BW+1)'(1)) begin
                                mode_d[i] = MODE_OFF;
                                done_d[i] = 1'b1;
                            end
                        end
`else
                        if (tick[i]) phase_d[i] = ~phase_q[i];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            flg     <= 1'b0;
            led     <= '0;
            phase_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= MODE_OFF;
                div_q[i]  <= '0;
            end
        end else begin
            cnt     <= cnt + 1'b1;
            flg     <= (cnt == '0);
            led     <= led_d;
            phase_q <= phase_d;
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= mode_d[i];
                div_q[i]  <= div_d[i];
            end
        end
    end

`ifdef BLINK_BURST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= '0;
            for (int i = 0; i < NCH; i++) rem_q[i] <= '0;
        end else begin
            done <= done_d;
            for (int i = 0; i < NCH; i++) rem_q[i] <= rem_d[i];
        end
    end
`else
    logic unused_cfg_cnt;
    assign unused_cfg_cnt = ^cfg_cnt;
    assign done = '0;
`endif

endmodule

// File: tb/tb_blink_multi.sv
// Bench for blink_multi: directed scenarios plus random writes, checked every cycle against a tick-counting model.
module tb_blink_multi;

    localparam int CBITS = 4;
    localparam int NCH   = 3;
    localparam int BW    = 8;
    localparam int DW    = $clog2(CBITS);
    localparam int CW    = NCH > 1 ? $clog2(NCH) : 1;
    localparam int W     = 2 * NCH + 1;
`ifdef BLINK_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [1:0]     cfg_mode;
    logic [DW-1:0]  cfg_div;
    logic [BW-1:0]  cfg_cnt;
    logic [NCH-1:0] led;
    logic           flg;
    logic [NCH-1:0] done;

    blink_multi #(.CBITS(CBITS), .NCH(NCH), .BW(BW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_cnt(cfg_cnt),
        .led(led), .flg(flg), .done(done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Each channel remembers its last write and how many ticks it has seen since;
    // the LED phase is the parity of that count and a burst ends after 2n ticks.
    int m_cnt;
    int m_mode  [NCH];
    int m_k     [NCH];
    int m_n     [NCH];
    int m_ticks [NCH];

    always @(posedge clk) begin
        logic [NCH-1:0] e_led;
        logic [NCH-1:0] e_done;
        logic           e_flg;
        int             eff;
        bit             tk;
        e_led  = '0;
        e_done = '0;
        e_flg  = 1'b0;
        if (rst) begin
            m_cnt = 0;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0; m_k[c] = 0; m_n[c] = 0; m_ticks[c] = 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                eff = (m_mode[c] == 3 && !BURST_EN) ? 2 : m_mode[c];
                e_led[c] = (eff == 1) || ((eff == 2 || eff == 3) && (m_ticks[c] % 2 == 1));
                tk = (m_cnt % (1 << (m_k[c] + 1))) == 0;
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_mode[c]  = int'(cfg_mode);
                    m_k[c]     = (int'(cfg_div) > CBITS - 1) ? CBITS - 1 : int'(cfg_div);
                    m_n[c]     = int'(cfg_cnt);
                    m_ticks[c] = 0;
                end else if (eff == 2) begin
                    if (tk) m_ticks[c]++;
                end else if (eff == 3) begin
                    if (m_n[c] == 0) begin
                        m_mode[c] = 0;
                        e_done[c] = 1'b1;
                    end else if (tk) begin
                        m_ticks[c]++;
                        if (m_ticks[c] == 2 * m_n[c]) begin
                            m_mode[c] = 0;
                            e_done[c] = 1'b1;
                        end
                    end
                end
            end
            e_flg = (m_cnt == 0);
            m_cnt = (m_cnt + 1) % (1 << CBITS);
        end
        exp_q.push_back({e_done, e_flg, e_led});
    end

    // ---------------- scoreboard monitor ----------------
    logic [NCH-1:0] prev_done = '0;
    int done1_total = 0;
    int led2_total  = 0;

    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {done, flg, led};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t actual done=%b flg=%b led=%b expected done=%b flg=%b led=%b",
                         $time, act_v[W-1 -: NCH], act_v[NCH], act_v[NCH-1:0],
                         exp_v[W-1 -: NCH], exp_v[NCH], exp_v[NCH-1:0]);
            end
            n_checks++;
            if ((done & prev_done) !== '0) begin
                n_fail++;
                $display("FAIL done_consecutive t=%0t actual prev=%b now=%b required no overlap",
                         $time, prev_done, done);
            end
            prev_done = done;
            if (done[1] === 1'b1) done1_total++;
            if (led[2] === 1'b1) led2_total++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input int ch, input int mode, input int div, input int cnt);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_mode = 2'(mode);
        cfg_div  = DW'(div);
        cfg_cnt  = BW'(cnt);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic check_count(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int snap;
        int guard;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_div = '0; cfg_cnt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(36);

        // channel 0 blinking at the fastest rate
        do_write(0, 2, 0, 0);
        idle(12);

        // channel 1 burst of three periods at k=1
        snap = done1_total;
        do_write(1, 3, 1, 3);
        idle(40);
        check_count("burst_done1_pulses", done1_total - snap, BURST_EN ? 1 : 0);

        // channel 2 zero-length burst: no LED activity when bursts are compiled in
        snap = led2_total;
        do_write(2, 3, 0, 0);
        idle(8);
        check_count("zero_burst_led2_high_cycles", (led2_total - snap) > 0 ? 1 : 0, BURST_EN ? 0 : 1);
        do_write(2, 0, 0, 0);
        idle(3);

        // write landing on a tick edge of channel 0, then an out-of-range channel write
        guard = 0;
        while ((m_cnt % 2) != 0 && guard < 4) begin
            idle(1);
            guard++;
        end
        check_count("tick_align_guard", (m_cnt % 2), 0);
        do_write(0, 2, 0, 0);
        do_write(NCH, 1, 3, 7);
        idle(10);

        // reset in the middle of a burst
        do_write(1, 3, 1, 5);
        idle(10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        snap = done1_total;
        idle(60);
        check_count("done1_after_reset", done1_total - snap, 0);

        // randomized writes and occasional resets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                idle($urandom_range(1, 2));
                rst = 1'b0;
            end
            do_write($urandom_range(0, NCH), $urandom_range(0, 3),
                     $urandom_range(0, CBITS - 1), $urandom_range(0, 3));
            idle($urandom_range(0, 25));
        end
        idle(4);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_count("scoreboard_drained", exp_q.size() > 1 ? 1 : 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
